alu_issue_stage: RTL

ID/EX issue register that sits directly upstream of the MIPS ALU. It decodes the 2-bit main-decoder ALU op and the R-type funct into the 4-bit ALU control code, selects and extends the second operand, and forwards write-back data. It holds one instruction behind a valid/ready handshake. While held, it snoops write-backs so a stalled instruction never issues stale operands.

---
 rtl/alu_issue_stage_if.sv | 43 ++++
 rtl/alu_issue_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Bundles the decode-side request, the write-back snoop port and the execute-side result
// of the ALU issue stage into one connection.
interface alu_issue_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic             alu_src;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [4:0]       dest_addr;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [15:0]      imm;
  logic             reg_write;

  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic [4:0]       out_dest;
  logic             out_reg_write;
  logic             out_illegal;

  modport slave (
    input  in_valid, alu_op, funct, alu_src, rs_addr, rt_addr, dest_addr,
           rs_data, rt_data, imm, reg_write, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, A, B, ALUControl, out_dest, out_reg_write, out_illegal
  );

  modport master (
    output in_valid, alu_op, funct, alu_src, rs_addr, rt_addr, dest_addr,
           rs_data, rt_data, imm, reg_write, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, A, B, ALUControl, out_dest, out_reg_write, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register in front of the MIPS ALU: decodes the ALU control code, selects operand B,
// and keeps a stalled instruction's operands current by snooping write-backs.
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  alu_issue_stage_if.slave bus
);
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  logic             validQ;
  logic [WIDTH-1:0] aQ;
  logic [WIDTH-1:0] bQ;
  logic [3:0]       ctrlQ;
  logic [4:0]       destQ;
  logic             regWriteQ;
  logic             illegalQ;
  logic [4:0]       heldRs;
  logic [4:0]       heldRt;
  logic             heldSrc;

  logic             capture;
  logic             holdSnoop;
  logic [3:0]       decCtrl;
  logic             decIllegal;
  logic [WIDTH-1:0] immExt;
  logic             rsFwd;
  logic             rtFwd;
  logic             heldRsHit;
  logic             heldRtHit;
  logic [WIDTH-1:0] capA;
  logic [WIDTH-1:0] capB;

  assign bus.in_ready = !validQ || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !flush;
  // Snooping only matters while the held instruction stays put; a consumed one has already left.
  assign holdSnoop    = validQ && !bus.out_ready;

  always_comb begin
    decCtrl    = CTRL_ILL;
    decIllegal = 1'b0;
    case (bus.alu_op)
      2'b00: decCtrl = CTRL_ADD;
      2'b01: decCtrl = CTRL_SUB;
      2'b11: decCtrl = CTRL_OR;
      default: begin
        case (bus.funct)
          FN_ADD:  decCtrl = CTRL_ADD;
          FN_SUB:  decCtrl = CTRL_SUB;
          FN_AND:  decCtrl = CTRL_AND;
          FN_OR:   decCtrl = CTRL_OR;
          FN_SLT:  decCtrl = CTRL_SLT;
          FN_NOR:  decCtrl = CTRL_NOR;
          default: begin
            decCtrl    = CTRL_ILL;
            decIllegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // ori zero-extends its immediate; every other immediate user wants sign extension.
  assign immExt = (bus.alu_op == 2'b11) ? {{(WIDTH-16){1'b0}}, bus.imm}
                                        : {{(WIDTH-16){bus.imm[15]}}, bus.imm};

  assign rsFwd     = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == bus.rs_addr);
  assign rtFwd     = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == bus.rt_addr);
  assign heldRsHit = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == heldRs);
  assign heldRtHit = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == heldRt) && !heldSrc;

  assign capA = rsFwd ? bus.wb_data : bus.rs_data;
  assign capB = bus.alu_src ? immExt : (rtFwd ? bus.wb_data : bus.rt_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ    <= 1'b0;
      aQ        <= '0;
      bQ        <= '0;
      ctrlQ     <= 4'b0000;
      destQ     <= 5'd0;
      regWriteQ <= 1'b0;
      illegalQ  <= 1'b0;
      heldRs    <= 5'd0;
      heldRt    <= 5'd0;
      heldSrc   <= 1'b0;
    end else begin
      if (flush) begin
        validQ <= 1'b0;
      end else if (capture) begin
        validQ <= 1'b1;
      end else if (bus.out_ready) begin
        validQ <= 1'b0;
      end

      if (capture) begin
        aQ        <= capA;
        bQ        <= capB;
        ctrlQ     <= decCtrl;
        destQ     <= bus.dest_addr;
        regWriteQ <= bus.reg_write && !decIllegal;
        illegalQ  <= decIllegal;
        heldRs    <= bus.rs_addr;
        heldRt    <= bus.rt_addr;
        heldSrc   <= bus.alu_src;
      end else if (holdSnoop) begin
        if (heldRsHit) aQ <= bus.wb_data;
        if (heldRtHit) bQ <= bus.wb_data;
      end
    end
  end

  assign bus.out_valid     = validQ;
  assign bus.A             = aQ;
  assign bus.B             = bQ;
  assign bus.ALUControl    = ctrlQ;
  assign bus.out_dest      = destQ;
  assign bus.out_reg_write = regWriteQ;
  assign bus.out_illegal   = illegalQ;
endmodule
